// File: rtl/serial_add_scheduler.sv
// serial_add_scheduler
//   Shares one LSB-first bit-serial adder (full adder + carry flop) between
//   NREQ requesters. Round-robin arbitration picks a requester in IDLE, its
//   operands are shifted through the adder for WIDTH cycles (SHIFT), and the
//   result is held on the response port until it is consumed (RESP).
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   req_valid_i  [NREQ]        per-requester operand valid
//   req_ready_o  [NREQ]        one-hot accept, asserted only in IDLE
//   req_a_i      [NREQ*WIDTH]  operand A, requester i at [i*WIDTH +: WIDTH]
//   req_b_i      [NREQ*WIDTH]  operand B, same packing
//   rsp_valid_o                result valid
//   rsp_ready_i                result consumer ready
//   rsp_sum_o    [WIDTH]       (a+b) mod 2^WIDTH
//   rsp_cout_o                 carry out of the MSB
//   rsp_id_o     [IDW]         requester that owns the result
//   busy_o                     high in SHIFT or RESP
module serial_add_scheduler #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 2,
  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid_i,
  output logic [NREQ-1:0]         req_ready_o,
  input  logic [NREQ*WIDTH-1:0]   req_a_i,
  input  logic [NREQ*WIDTH-1:0]   req_b_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [WIDTH-1:0]        rsp_sum_o,
  output logic                    rsp_cout_o,
  output logic [IDW-1:0]          rsp_id_o,
  output logic                    busy_o
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   last_grant_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             carry_q;
  logic [CW-1:0]    count_q;
  logic             rsp_cout_q;
  logic [IDW-1:0]   rsp_id_q;

  logic             any_valid;
  logic [IDW-1:0]   grant;
  logic [WIDTH-1:0] a_sel, b_sel;
  logic             s_bit, maj_bit, last_bit;
  logic [WIDTH-1:0] sum_d;

  // Round-robin search starting just after the previous winner.
  always_comb begin
    int             idx;
    logic [IDW-1:0] idx_v;
    any_valid = 1'b0;
    grant     = '0;
    idx       = 0;
    idx_v     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx   = (int'(last_grant_q) + k) % NREQ;
      idx_v = IDW'(idx);
      if (!any_valid && req_valid_i[idx_v]) begin
        any_valid = 1'b1;
        grant     = idx_v;
      end
    end
  end

  // Operand mux for the granted requester.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant == IDW'(i)) begin
        a_sel = req_a_i[i*WIDTH +: WIDTH];
        b_sel = req_b_i[i*WIDTH +: WIDTH];
      end
    end
  end

  // One full-adder slice; the sum bit enters at the MSB so the LSB-first
  // stream ends up in natural bit order after WIDTH shifts.
  assign s_bit    = a_q[0] ^ b_q[0] ^ carry_q;
  assign maj_bit  = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
  assign sum_d    = (sum_q >> 1) | (WIDTH'(s_bit) << (WIDTH - 1));
  assign last_bit = (count_q == CW'(WIDTH - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_valid)   state_d = SHIFT;
      SHIFT:   if (last_bit)    state_d = RESP;
      RESP:    if (rsp_ready_i) state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    req_ready_o = '0;
    if (state_q == IDLE && any_valid) req_ready_o[grant] = 1'b1;
  end

  assign busy_o      = (state_q != IDLE);
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_sum_o   = sum_q;
  assign rsp_cout_o  = rsp_cout_q;
  assign rsp_id_o    = rsp_id_q;

  // Datapath: operand capture on accept, one bit per SHIFT cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= IDW'(NREQ - 1);
      a_q          <= '0;
      b_q          <= '0;
      sum_q        <= '0;
      carry_q      <= 1'b0;
      count_q      <= '0;
      rsp_cout_q   <= 1'b0;
      rsp_id_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_valid) begin
            a_q          <= a_sel;
            b_q          <= b_sel;
            rsp_id_q     <= grant;
            carry_q      <= 1'b0;
            count_q      <= '0;
            last_grant_q <= grant;
          end
        end
        SHIFT: begin
          carry_q <= maj_bit;
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          sum_q   <= sum_d;
          count_q <= count_q + CW'(1);
          if (last_bit) rsp_cout_q <= maj_bit;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_scheduler.sv
module tb_serial_add_scheduler;
  localparam int WIDTH = 4;
  localparam int NREQ  = 2;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [NREQ-1:0]       req_valid_i = '0;
  logic [NREQ-1:0]       req_ready_o;
  logic [NREQ*WIDTH-1:0] req_a_i = '0;
  logic [NREQ*WIDTH-1:0] req_b_i = '0;
  logic                  rsp_valid_o;
  logic                  rsp_ready_i = 1'b0;
  logic [WIDTH-1:0]      rsp_sum_o;
  logic                  rsp_cout_o;
  logic [0:0]            rsp_id_o;
  logic                  busy_o;

  serial_add_scheduler #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_a_i     (req_a_i),
    .req_b_i     (req_b_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_sum_o   (rsp_sum_o),
    .rsp_cout_o  (rsp_cout_o),
    .rsp_id_o    (rsp_id_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  int lg;  // reference model: last granted requester

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    req_valid_i = '0;
    rsp_ready_i = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    lg = NREQ - 1;
  endtask

  // Round-robin reference: first valid index after the previous winner.
  function automatic int rr_pick(input logic [NREQ-1:0] v, input int last);
    for (int k = 1; k <= NREQ; k++)
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  // Drives one request through to a consumed response and reports what it saw.
  task automatic run_op(input logic [NREQ-1:0] vmask,
                        input logic [3:0] a0, input logic [3:0] b0,
                        input logic [3:0] a1, input logic [3:0] b1,
                        input bit hold,
                        output int grant, output int acc_cyc, output int rsp_cyc,
                        output logic [3:0] sum, output logic cout, output logic id,
                        output bit tmo);
    int n;
    tmo = 1'b0; grant = -1; acc_cyc = 0; rsp_cyc = 0; sum = '0; cout = 1'b0; id = 1'b0;
    req_valid_i = vmask;
    req_a_i     = {a1, a0};
    req_b_i     = {b1, b0};
    rsp_ready_i = 1'b1;
    #1;
    n = 0;
    while (req_ready_o == '0 && n < 20) begin tick(); n++; end
    if (req_ready_o == '0) begin tmo = 1'b1; req_valid_i = '0; return; end
    grant   = req_ready_o[1] ? 1 : 0;
    acc_cyc = cyc;
    tick();
    if (!hold) req_valid_i = '0;
    n = 0;
    while (!rsp_valid_o && n < 20) begin tick(); n++; end
    if (!rsp_valid_o) begin tmo = 1'b1; return; end
    rsp_cyc = cyc;
    sum  = rsp_sum_o;
    cout = rsp_cout_o;
    id   = rsp_id_o;
    tick();
  endtask

  task automatic test_reset();
    apply_reset();
    repeat (5) tick();
    n_checks++; if (req_ready_o !== 2'b00) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 00", req_ready_o); end
    n_checks++; if (rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid_o); end
    n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
    n_checks++; if (rsp_id_o !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_id: got %b expected 0", rsp_id_o); end
    n_checks++; if (rsp_sum_o !== 4'h0 || rsp_cout_o !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_data: got %h/%b expected 0/0", rsp_sum_o, rsp_cout_o); end
  endtask

  task automatic test_basic();
    int g, ac, rc; logic [3:0] s; logic c, id; bit tmo;
    run_op(2'b01, 4'hB, 4'h6, 4'h0, 4'h0, 1'b0, g, ac, rc, s, c, id, tmo);
    n_checks++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL basic_timeout: got %b expected 0", tmo); end
    n_checks++; if (g !== 0) begin n_fail++; $display("FAIL basic_grant: got %0d expected 0", g); end
    n_checks++; if (rc - ac !== WIDTH + 1) begin n_fail++; $display("FAIL basic_latency: got %0d expected %0d", rc - ac, WIDTH + 1); end
    n_checks++; if (s !== 4'h1) begin n_fail++; $display("FAIL basic_sum: got %h expected 1", s); end
    n_checks++; if (c !== 1'b1) begin n_fail++; $display("FAIL basic_cout: got %b expected 1", c); end
    n_checks++; if (id !== 1'b0) begin n_fail++; $display("FAIL basic_id: got %b expected 0", id); end
    n_checks++; if (rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL basic_pulse: got %b expected 0", rsp_valid_o); end
    lg = 0;
  endtask

  task automatic test_round_robin();
    int g, ac, rc, prev_ac, eg, a_i, b_i; logic [3:0] s, a0, b0, a1, b1; logic c, id; bit tmo;
    apply_reset();
    prev_ac = 0;
    for (int op = 0; op < 3; op++) begin
      a0 = 4'($urandom); b0 = 4'($urandom); a1 = 4'($urandom); b1 = 4'($urandom);
      eg = rr_pick(2'b11, lg);
      run_op(2'b11, a0, b0, a1, b1, 1'b1, g, ac, rc, s, c, id, tmo);
      a_i = (eg == 1) ? int'(a1) : int'(a0);
      b_i = (eg == 1) ? int'(b1) : int'(b0);
      n_checks++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL rr_timeout op%0d: got %b expected 0", op, tmo); end
      n_checks++; if (g !== eg) begin n_fail++; $display("FAIL rr_grant op%0d: got %0d expected %0d", op, g, eg); end
      n_checks++; if (int'(id) !== eg) begin n_fail++; $display("FAIL rr_id op%0d: got %0d expected %0d", op, id, eg); end
      n_checks++; if ({c, s} !== 5'(a_i + b_i)) begin n_fail++; $display("FAIL rr_result op%0d: got %b_%h expected %h", op, c, s, 5'(a_i + b_i)); end
      if (op > 0) begin
        n_checks++; if (ac - prev_ac !== WIDTH + 2) begin n_fail++; $display("FAIL rr_spacing op%0d: got %0d expected %0d", op, ac - prev_ac, WIDTH + 2); end
      end
      prev_ac = ac;
      lg = eg;
    end
    req_valid_i = '0;
    tick();
  endtask

  task automatic test_backpressure();
    int n;
    req_valid_i = 2'b10;
    req_a_i = {4'hF, 4'h0};
    req_b_i = {4'h1, 4'h0};
    rsp_ready_i = 1'b0;
    #1;
    n = 0;
    while (req_ready_o == '0 && n < 20) begin tick(); n++; end
    n_checks++; if (req_ready_o !== 2'b10) begin n_fail++; $display("FAIL bp_accept: got %b expected 10", req_ready_o); end
    tick();
    req_valid_i = 2'b01;  // competing request must not be accepted while busy
    n = 0;
    while (!rsp_valid_o && n < 20) begin tick(); n++; end
    for (int k = 0; k < 3; k++) begin
      n_checks++; if (rsp_valid_o !== 1'b1) begin n_fail++; $display("FAIL bp_valid_hold c%0d: got %b expected 1", k, rsp_valid_o); end
      n_checks++; if (rsp_sum_o !== 4'h0 || rsp_cout_o !== 1'b1) begin n_fail++; $display("FAIL bp_data_hold c%0d: got %h/%b expected 0/1", k, rsp_sum_o, rsp_cout_o); end
      n_checks++; if (rsp_id_o !== 1'b1) begin n_fail++; $display("FAIL bp_id_hold c%0d: got %b expected 1", k, rsp_id_o); end
      n_checks++; if (req_ready_o !== 2'b00) begin n_fail++; $display("FAIL bp_ready_low c%0d: got %b expected 00", k, req_ready_o); end
      tick();
    end
    req_valid_i = '0;
    rsp_ready_i = 1'b1;
    tick();
    n_checks++; if (rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL bp_release: got %b expected 0", rsp_valid_o); end
    n_checks++; if (rsp_sum_o !== 4'h0 || rsp_cout_o !== 1'b1 || rsp_id_o !== 1'b1) begin n_fail++; $display("FAIL bp_keep: got %h/%b/%b expected 0/1/1", rsp_sum_o, rsp_cout_o, rsp_id_o); end
    lg = 1;
  endtask

  task automatic test_reset_abort();
    int n, g, ac, rc; logic [3:0] s; logic c, id; bit tmo, seen;
    req_valid_i = 2'b01;
    req_a_i = {4'h0, 4'h3};
    req_b_i = {4'h0, 4'h5};
    rsp_ready_i = 1'b1;
    #1;
    n = 0;
    while (req_ready_o == '0 && n < 20) begin tick(); n++; end
    tick();          // first SHIFT cycle
    req_valid_i = '0;
    tick();          // second SHIFT cycle
    #2 rst = 1'b1;
    #1;
    n_checks++; if (busy_o !== 1'b0 || rsp_valid_o !== 1'b0 || req_ready_o !== 2'b00) begin n_fail++; $display("FAIL abort_ctrl: got busy=%b valid=%b ready=%b expected 0/0/00", busy_o, rsp_valid_o, req_ready_o); end
    n_checks++; if (rsp_sum_o !== 4'h0 || rsp_cout_o !== 1'b0 || rsp_id_o !== 1'b0) begin n_fail++; $display("FAIL abort_data: got %h/%b/%b expected 0/0/0", rsp_sum_o, rsp_cout_o, rsp_id_o); end
    tick();
    rst = 1'b0;
    lg = NREQ - 1;
    seen = 1'b0;
    repeat (8) begin tick(); if (rsp_valid_o) seen = 1'b1; end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL abort_no_rsp: got %b expected 0", seen); end
    run_op(2'b01, 4'h3, 4'h5, 4'h0, 4'h0, 1'b0, g, ac, rc, s, c, id, tmo);
    n_checks++; if (tmo !== 1'b0 || g !== 0) begin n_fail++; $display("FAIL abort_next_grant: got %0d tmo=%b expected 0", g, tmo); end
    n_checks++; if (s !== 4'h8 || c !== 1'b0) begin n_fail++; $display("FAIL abort_next_result: got %h/%b expected 8/0", s, c); end
    lg = 0;
  endtask

  task automatic test_operand_hold();
    int n;
    req_valid_i = 2'b01;
    req_a_i = '0;
    req_b_i = '0;
    rsp_ready_i = 1'b1;
    #1;
    n = 0;
    while (req_ready_o == '0 && n < 20) begin tick(); n++; end
    tick();
    req_valid_i = '0;
    req_a_i = {4'h0, 4'hF};  // late change must not reach the sum
    n = 0;
    while (!rsp_valid_o && n < 20) begin tick(); n++; end
    n_checks++; if (rsp_valid_o !== 1'b1) begin n_fail++; $display("FAIL hold_timeout: got %b expected 1", rsp_valid_o); end
    n_checks++; if (rsp_sum_o !== 4'h0 || rsp_cout_o !== 1'b0) begin n_fail++; $display("FAIL hold_result: got %h/%b expected 0/0", rsp_sum_o, rsp_cout_o); end
    tick();
    lg = 0;
  endtask

  task automatic test_random();
    int g, ac, rc, eg, a_i, b_i; logic [3:0] s, a0, b0, a1, b1; logic c, id; bit tmo;
    logic [NREQ-1:0] m;
    apply_reset();
    for (int op = 0; op < 16; op++) begin
      m  = 2'($urandom_range(1, 3));
      a0 = 4'($urandom); b0 = 4'($urandom); a1 = 4'($urandom); b1 = 4'($urandom);
      eg = rr_pick(m, lg);
      a_i = (eg == 1) ? int'(a1) : int'(a0);
      b_i = (eg == 1) ? int'(b1) : int'(b0);
      run_op(m, a0, b0, a1, b1, 1'b0, g, ac, rc, s, c, id, tmo);
      n_checks++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL rnd_timeout op%0d: got %b expected 0", op, tmo); end
      n_checks++; if (g !== eg || int'(id) !== eg) begin n_fail++; $display("FAIL rnd_grant op%0d: got grant=%0d id=%0d expected %0d", op, g, id, eg); end
      n_checks++; if ({c, s} !== 5'(a_i + b_i)) begin n_fail++; $display("FAIL rnd_result op%0d: got %b_%h expected %h", op, c, s, 5'(a_i + b_i)); end
      n_checks++; if (rc - ac !== WIDTH + 1) begin n_fail++; $display("FAIL rnd_latency op%0d: got %0d expected %0d", op, rc - ac, WIDTH + 1); end
      lg = eg;
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_basic();
    test_round_robin();
    test_backpressure();
    test_reset_abort();
    test_operand_hold();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
